// File: rtl/cond_unit_if.sv
// Execute-stage conditional-execution bundle: decoder/ALU strobes in,
// condition result, gated strobes and architectural flags out.
interface cond_unit_if;
    logic       En;
    logic       Valid;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       CondEx;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic [3:0] Flags;

    modport master (
        output En, Valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
        input  CondEx, PCSrc, RegWrite, MemWrite, Flags
    );

    modport slave (
        input  En, Valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
        output CondEx, PCSrc, RegWrite, MemWrite, Flags
    );
endinterface

// File: rtl/cond_unit.sv
// Conditional-execution unit: holds NZCV, evaluates the condition field
// against it and gates PC/register/memory write strobes.
module cond_unit (
    input  logic        clk,
    input  logic        reset,
    cond_unit_if.slave  cu
);
    logic [3:0] flags_q;
    logic       n, z, c, v;
    logic       cond_ex;
    logic       pass;

    assign {n, z, c, v} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (cu.Cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // An instruction in execute during a reset cycle must not commit anything.
    assign pass = cond_ex & cu.Valid & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (cu.En && pass) begin
            if (cu.FlagW[1]) flags_q[3:2] <= cu.ALUFlags[3:2];
            if (cu.FlagW[0]) flags_q[1:0] <= cu.ALUFlags[1:0];
        end
    end

    assign cu.CondEx   = cond_ex;
    assign cu.PCSrc    = cu.PCS & pass;
    assign cu.RegWrite = cu.RegW & ~cu.NoWrite & pass;
    assign cu.MemWrite = cu.MemW & pass;
    assign cu.Flags    = flags_q;
endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit: vector table for the main sequence, plus a
// full flags x cond sweep and back-to-back / stall sequences.
module tb_cond_unit;
    logic clk = 1'b0;
    logic reset;
    cond_unit_if cu_bus ();

    cond_unit dut (.clk(clk), .reset(reset), .cu(cu_bus));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rst, en, valid;
        logic [3:0] cond, alu;
        logic [1:0] fw;
        logic       pcs, regw, memw, nw;
        logic       chk_cx, cx, pcsrc, rw, mw;
        logic [3:0] flags;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic model_cond(input logic [3:0] f, input logic [3:0] cd);
        logic fn, fz, fc, fv, base;
        {fn, fz, fc, fv} = f;
        case (cd[3:1])
            3'd0: base = fz;
            3'd1: base = fc;
            3'd2: base = fn;
            3'd3: base = fv;
            3'd4: base = fc & ~fz;
            3'd5: base = (fn == fv);
            3'd6: base = ~fz & (fn == fv);
            default: base = 1'b1;
        endcase
        if (cd == 4'hF) return 1'b0;
        return cd[0] ? ~base : base;
    endfunction

    task automatic drive(input logic rst, input logic en, input logic valid,
                         input logic [3:0] cond, input logic [3:0] alu, input logic [1:0] fw,
                         input logic pcs, input logic regw, input logic memw, input logic nw);
        reset            = rst;
        cu_bus.En        = en;
        cu_bus.Valid     = valid;
        cu_bus.Cond      = cond;
        cu_bus.ALUFlags  = alu;
        cu_bus.FlagW     = fw;
        cu_bus.PCS       = pcs;
        cu_bus.RegW      = regw;
        cu_bus.MemW      = memw;
        cu_bus.NoWrite   = nw;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        //                      rst   en    valid cond   alu    fw     pcs   regw  memw  nw    chk   cx    pcsrc rw    mw    flags
        vecs.push_back(vec_t'{1'b1, 1'b1, 1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000});
        vecs.push_back(vec_t'{1'b1, 1'b1, 1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 4'h1, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 4'hE, 4'h6, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0110});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 4'h8, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 4'hE, 4'hF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 4'hE, 4'h0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 4'hE, 4'hE, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010});
        vecs.push_back(vec_t'{1'b1, 1'b1, 1'b1, 4'hE, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 4'h0, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 4'hE, 4'h8, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 4'hE, 4'h8, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 4'hE, 4'h5, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 4'hE, 4'h3, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1011});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 4'hE, 4'h9, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 4'hA, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 4'hD, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 4'hF, 4'h6, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001});
        vecs.push_back(vec_t'{1'b1, 1'b1, 1'b1, 4'hE, 4'hF, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000});

        tick();
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].valid, vecs[i].cond, vecs[i].alu, vecs[i].fw,
                  vecs[i].pcs, vecs[i].regw, vecs[i].memw, vecs[i].nw);
            #1;
            if (vecs[i].chk_cx) check($sformatf("v%0d CondEx", i), {3'b0, cu_bus.CondEx}, {3'b0, vecs[i].cx});
            check($sformatf("v%0d PCSrc", i),    {3'b0, cu_bus.PCSrc},    {3'b0, vecs[i].pcsrc});
            check($sformatf("v%0d RegWrite", i), {3'b0, cu_bus.RegWrite}, {3'b0, vecs[i].rw});
            check($sformatf("v%0d MemWrite", i), {3'b0, cu_bus.MemWrite}, {3'b0, vecs[i].mw});
            tick();
            check($sformatf("v%0d Flags", i), cu_bus.Flags, vecs[i].flags);
        end

        // Full condition sweep; Valid low while sweeping to show CondEx is ungated.
        for (int f = 0; f < 16; f++) begin
            drive(1'b0, 1'b1, 1'b1, 4'hE, f[3:0], 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            check($sformatf("sweep load %0d", f), cu_bus.Flags, f[3:0]);
            cu_bus.Valid = 1'b0;
            cu_bus.FlagW = 2'b00;
            for (int cd = 0; cd < 16; cd++) begin
                cu_bus.Cond = cd[3:0];
                #1;
                check($sformatf("sweep f=%b c=%b CondEx", f[3:0], cd[3:0]),
                      {3'b0, cu_bus.CondEx}, {3'b0, model_cond(f[3:0], cd[3:0])});
            end
            tick();
        end

        // Back-to-back: B sees A's flags in the very next cycle.
        drive(1'b0, 1'b1, 1'b1, 4'hE, 4'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 4'h1, 4'h4, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("b2b NE CondEx", {3'b0, cu_bus.CondEx}, 4'b0001);
        check("b2b NE PCSrc",  {3'b0, cu_bus.PCSrc},  4'b0001);
        tick();
        check("b2b Flags", cu_bus.Flags, 4'b0100);

        // Stall two cycles, update lands on the first enabled edge.
        drive(1'b0, 1'b0, 1'b1, 4'hE, 4'h3, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("stall1 Flags", cu_bus.Flags, 4'b0100);
        tick();
        check("stall2 Flags", cu_bus.Flags, 4'b0100);
        cu_bus.En = 1'b1;
        tick();
        check("stall release Flags", cu_bus.Flags, 4'b0111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end
endmodule
